// File: rtl/mux_scan_reg_if.sv
// rtl/mux_scan_reg_if.sv - signal bundle between the lane bank and the registered scanning mux
interface mux_scan_reg_if #(
  parameter int N     = 16,
  parameter int W     = 1,
  parameter int SEL_W = 4
);
  logic [N*W-1:0]   I;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic             sel_load;
  logic             start;
  logic [SEL_W-1:0] sel_cur;
  logic [W-1:0]     y;
  logic             y_valid;
  logic             sel_err;
  logic             busy;
  logic             scan_done;

  modport master (
    output I, mode, sel_in, sel_load, start,
    input  sel_cur, y, y_valid, sel_err, busy, scan_done
  );

  modport slave (
    input  I, mode, sel_in, sel_load, start,
    output sel_cur, y, y_valid, sel_err, busy, scan_done
  );
endinterface

// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - registered N:1 channel mux with held select and auto-scan sequencer
module mux_scan_reg #(
  parameter int N     = 16,
  parameter int W     = 1,
  parameter int SEL_W = 4,
  parameter int HOLD  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_scan_reg_if.slave  bus
);
  localparam int DW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW-1:0]    DWELL_LAST = DW'(HOLD - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic [DW-1:0]    dwell_q, dwell_nx;
  logic             valid_q, valid_nx;
  logic [W-1:0]     y_q, y_nx;
  logic             err_q, err_nx;

  // Datapath follows whatever the select register holds, in every state.
  always_comb begin
    y_nx = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_q == SEL_W'(k)) y_nx = bus.I[k*W +: W];
    end
    err_nx = ({1'b0, sel_q} >= (SEL_W+1)'(N));
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    dwell_nx = dwell_q;
    valid_nx = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && bus.mode) begin
          state_nx = SCAN;
          sel_nx   = '0;
          dwell_nx = '0;
        end else if (bus.sel_load) begin
          sel_nx = bus.sel_in;
        end
      end
      SCAN: begin
        // Abort wins over a completing dwell, so a partial sample is never flagged valid.
        if (!bus.mode) begin
          state_nx = IDLE;
          dwell_nx = '0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_nx = '0;
          valid_nx = 1'b1;
          if (sel_q == SEL_LAST) state_nx = DONE;
          else                   sel_nx   = sel_q + SEL_W'(1);
        end else begin
          dwell_nx = dwell_q + DW'(1);
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= '0;
      dwell_q <= '0;
      valid_q <= 1'b0;
      y_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      sel_q   <= sel_nx;
      dwell_q <= dwell_nx;
      valid_q <= valid_nx;
      y_q     <= y_nx;
      err_q   <= err_nx;
    end
  end

  assign bus.sel_cur   = sel_q;
  assign bus.y         = y_q;
  assign bus.y_valid   = valid_q;
  assign bus.sel_err   = err_q;
  assign bus.busy      = (state == SCAN);
  assign bus.scan_done = (state == DONE);
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb/tb_mux_scan_reg.sv - table-driven and scoreboard checks of mux_scan_reg in three configurations
module tb_mux_scan_reg;
  logic clk;
  logic rst_n;

  mux_scan_reg_if #(.N(16), .W(1), .SEL_W(4)) ia ();
  mux_scan_reg_if #(.N(4),  .W(8), .SEL_W(2)) ib ();
  mux_scan_reg_if #(.N(12), .W(1), .SEL_W(4)) ic ();

  mux_scan_reg #(.N(16), .W(1), .SEL_W(4), .HOLD(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  mux_scan_reg #(.N(4),  .W(8), .SEL_W(2), .HOLD(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  mux_scan_reg #(.N(12), .W(1), .SEL_W(4), .HOLD(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic [15:0] i;
    logic [3:0]  sel;
    logic        y;
    logic        err;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic       err;
  } exp_t;

  vec_t tbl[23];
  exp_t sb[$];
  exp_t e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   busy_n;
  bit   found;
  logic [15:0] pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 16; k++) tbl[k] = '{0, 16'(1 << k), 4'(k), 1'b1, 1'b0};
    tbl[16] = '{0, 16'h0008, 4'd5,  1'b0, 1'b0};
    tbl[17] = '{0, 16'hFF7F, 4'd7,  1'b0, 1'b0};
    tbl[18] = '{0, 16'hFFFF, 4'd15, 1'b1, 1'b0};
    tbl[19] = '{1, 16'h0FFF, 4'd13, 1'b0, 1'b1};
    tbl[20] = '{1, 16'h0FFF, 4'd11, 1'b1, 1'b0};
    tbl[21] = '{1, 16'h0FFF, 4'd12, 1'b0, 1'b1};
    tbl[22] = '{1, 16'h07FF, 4'd11, 1'b0, 1'b0};

    rst_n = 1'b0;
    ia.I = '0; ia.mode = 0; ia.sel_in = '0; ia.sel_load = 0; ia.start = 0;
    ib.I = '0; ib.mode = 0; ib.sel_in = '0; ib.sel_load = 0; ib.start = 0;
    ic.I = '0; ic.mode = 0; ic.sel_in = '0; ic.sel_load = 0; ic.start = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_sel",   32'(ia.sel_cur), 0);
    check("rst_y",     32'(ia.y), 0);
    check("rst_flags", {28'd0, ia.y_valid, ia.sel_err, ia.busy, ia.scan_done}, 0);

    // Asynchronous reset lands between clock edges.
    ia.I = 16'hFFFF; ia.sel_in = 4'd5; ia.sel_load = 1;
    tick();
    ia.sel_load = 0;
    tick();
    check("pre_rst_sel", 32'(ia.sel_cur), 5);
    check("pre_rst_y",   32'(ia.y), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_sel",   32'(ia.sel_cur), 0);
    check("async_rst_y",     32'(ia.y), 0);
    check("async_rst_flags", {28'd0, ia.y_valid, ia.sel_err, ia.busy, ia.scan_done}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 23; v++) begin
      if (tbl[v].dut == 0) begin
        ia.I = tbl[v].i; ia.sel_in = tbl[v].sel; ia.sel_load = 1;
      end else begin
        ic.I = tbl[v].i[11:0]; ic.sel_in = tbl[v].sel; ic.sel_load = 1;
      end
      sb.push_back('{y: 8'(tbl[v].y), err: tbl[v].err});
      tick();
      ia.sel_load = 0; ic.sel_load = 0;
      tick();
      e = sb.pop_front();
      if (tbl[v].dut == 0) begin
        check($sformatf("vec%0d_y", v),   32'(ia.y), 32'(e.y));
        check($sformatf("vec%0d_err", v), 32'(ia.sel_err), 32'(e.err));
      end else begin
        check($sformatf("vec%0d_y", v),   32'(ic.y), 32'(e.y));
        check($sformatf("vec%0d_err", v), 32'(ic.sel_err), 32'(e.err));
      end
    end

    // Scan sweep N=4 W=8 HOLD=3: a sample every third cycle, done with the last one.
    ib.I = 32'hD4C3B2A1;
    ib.mode = 1; ib.start = 1;
    tick();
    ib.start = 0;
    sb.push_back('{y: 8'hA1, err: 1'b0});
    sb.push_back('{y: 8'hB2, err: 1'b0});
    sb.push_back('{y: 8'hC3, err: 1'b0});
    sb.push_back('{y: 8'hD4, err: 1'b0});
    busy_n = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      if (ib.busy) busy_n++;
      check($sformatf("scan_valid_k%0d", k), 32'(ib.y_valid), 32'(k >= 3 && k <= 12 && (k % 3) == 0));
      check($sformatf("scan_done_k%0d", k),  32'(ib.scan_done), 32'(k == 12));
      if (ib.y_valid && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("scan_y_k%0d", k), 32'(ib.y), 32'(e.y));
      end
    end
    check("scan_busy_cycles", 32'(busy_n), 12);
    check("scan_sb_empty", 32'(sb.size()), 0);
    ib.mode = 0;

    // Abort N=16 HOLD=1 at channel 6.
    pat = 16'hA5E3;
    ia.I = pat; ia.mode = 1; ia.start = 1;
    tick();
    ia.start = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (ia.sel_cur == 4'd6) found = 1;
      else tick();
    end
    check("abort_reach_ch6", 32'(found), 1);
    check("abort_pre_valid", 32'(ia.y_valid), 1);
    check("abort_pre_y",     32'(ia.y), 32'(pat[5]));
    ia.mode = 0;
    tick();
    check("abort_busy",  32'(ia.busy), 0);
    check("abort_sel",   32'(ia.sel_cur), 6);
    check("abort_valid", 32'(ia.y_valid), 0);
    check("abort_done",  32'(ia.scan_done), 0);
    tick();
    check("abort_done2",  32'(ia.scan_done), 0);
    check("abort_valid2", 32'(ia.y_valid), 0);
    ia.start = 1;
    tick();
    ia.start = 0;
    check("start_mode0_busy", 32'(ia.busy), 0);
    check("start_mode0_sel",  32'(ia.sel_cur), 6);

    // start beats sel_load in IDLE; sel_load ignored while scanning.
    ia.mode = 1; ia.start = 1; ia.sel_load = 1; ia.sel_in = 4'd9;
    tick();
    ia.start = 0; ia.sel_in = 4'd12;
    check("prio_busy", 32'(ia.busy), 1);
    check("prio_sel",  32'(ia.sel_cur), 0);
    tick();
    ia.sel_load = 0;
    check("scan_load_ignored", 32'(ia.sel_cur), 1);
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      if (ia.scan_done) found = 1;
      else tick();
    end
    check("sweep_done_seen", 32'(found), 1);
    check("sweep_done_sel",  32'(ia.sel_cur), 15);
    check("sweep_done_valid", 32'(ia.y_valid), 1);
    check("sweep_done_y",    32'(ia.y), 32'(pat[15]));
    tick();
    check("sweep_idle_busy", 32'(ia.busy), 0);
    check("sweep_idle_done", 32'(ia.scan_done), 0);
    ia.mode = 0;

    // Reset in the middle of a sweep.
    ib.mode = 1; ib.start = 1;
    tick();
    ib.start = 0;
    tick(); tick(); tick(); tick();
    check("midscan_busy_before", 32'(ib.busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("midscan_rst_busy", 32'(ib.busy), 0);
    check("midscan_rst_sel",  32'(ib.sel_cur), 0);
    check("midscan_rst_y",    32'(ib.y), 0);
    check("midscan_rst_flags", {29'd0, ib.y_valid, ib.sel_err, ib.scan_done}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
